// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - ARM-style condition check, flag registers and write-enable gating
//
// Ports:
//   clk       in   1  rising-edge clock
//   reset     in   1  asynchronous active-low reset
//   Cond      in   4  instruction condition field
//   ALUFlags  in   4  ALU flags this cycle {N,Z,C,V}
//   FlagW     in   2  flag write request: [1] -> N,Z  [0] -> C,V
//   PCS       in   1  PC write request
//   RegW      in   1  register-file write request
//   MemW      in   1  data-memory write request
//   NoWrite   in   1  suppress register write (compare/test ops)
//   PCSrc     out  1  gated PC write
//   RegWrite  out  1  gated register-file write
//   MemWrite  out  1  gated memory write
//   CondEx    out  1  condition passed this cycle
//   Flags     out  4  stored flags {N,Z,C,V}
module cond_logic #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    logic [1:0] nz_q, nz_d;
    logic [1:0] cv_q, cv_d;
    logic       cond_ex;

    logic n_flag, z_flag, c_flag, v_flag;

    assign n_flag = nz_q[1];
    assign z_flag = nz_q[0];
    assign c_flag = cv_q[1];
    assign v_flag = cv_q[0];

    // Condition uses stored flags only, so a flag-setting instruction is
    // evaluated against the flags left by the previous instruction.
    always_comb begin
        cond_ex = 1'b0;
        unique case (Cond)
            4'b0000: cond_ex = z_flag;
            4'b0001: cond_ex = ~z_flag;
            4'b0010: cond_ex = c_flag;
            4'b0011: cond_ex = ~c_flag;
            4'b0100: cond_ex = n_flag;
            4'b0101: cond_ex = ~n_flag;
            4'b0110: cond_ex = v_flag;
            4'b0111: cond_ex = ~v_flag;
            4'b1000: cond_ex = c_flag & ~z_flag;
            4'b1001: cond_ex = ~c_flag | z_flag;
            4'b1010: cond_ex = (n_flag == v_flag);
            4'b1011: cond_ex = (n_flag != v_flag);
            4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
            4'b1101: cond_ex = z_flag | (n_flag != v_flag);
            4'b1110: cond_ex = 1'b1;
            4'b1111: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // NZ and CV halves are written independently.
    always_comb begin
        nz_d = nz_q;
        cv_d = cv_q;
        if (FlagW[1] && cond_ex) begin
            nz_d = ALUFlags[3:2];
        end
        if (FlagW[0] && cond_ex) begin
            cv_d = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nz_q <= RESET_FLAGS[3:2];
            cv_q <= RESET_FLAGS[1:0];
        end else begin
            nz_q <= nz_d;
            cv_q <= cv_d;
        end
    end

    assign CondEx   = cond_ex;
    assign PCSrc    = PCS & cond_ex;
    assign MemWrite = MemW & cond_ex;
    assign RegWrite = RegW & cond_ex & ~NoWrite;
    assign Flags    = {nz_q, cv_q};

endmodule

// File: tb/tb_cond_logic.sv
// tb/tb_cond_logic.sv - scoreboard bench for cond_logic with randomized and directed stimulus
module tb_cond_logic;

    localparam logic [3:0] RST_FLAGS = 4'b0000;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    cond_logic #(.RESET_FLAGS(RST_FLAGS)) dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       condex;
        logic       pcsrc;
        logic       regwrite;
        logic       memwrite;
        logic [3:0] flags;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] model_flags;

    // Condition pairs: odd codes are the negation of the even code below them,
    // except 1111 which is unconditional like 1110.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        if (c == 4'hF) return 1'b1;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic chk(input string tag, input string field, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %0h expected %0h", tag, field, act, exp);
        end
    endtask

    // Monitor: compare every pending expectation at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk(e.tag, "CondEx",   {3'b0, CondEx},   {3'b0, e.condex});
                chk(e.tag, "PCSrc",    {3'b0, PCSrc},    {3'b0, e.pcsrc});
                chk(e.tag, "RegWrite", {3'b0, RegWrite}, {3'b0, e.regwrite});
                chk(e.tag, "MemWrite", {3'b0, MemWrite}, {3'b0, e.memwrite});
                chk(e.tag, "Flags",    Flags,            e.flags);
            end
        end
    end

    // One cycle of stimulus: drive after the rising edge, optionally assert
    // reset mid-cycle, push the expectation, then advance the model to what
    // the next rising edge should store.
    task automatic step(input string tag, input logic rst_val, input logic mid_rst,
                        input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu,
                        input logic pcs, input logic regw, input logic memw, input logic nw);
        exp_t e;
        logic p;
        @(posedge clk);
        #1;
        reset    = rst_val;
        Cond     = c;
        FlagW    = fw;
        ALUFlags = alu;
        PCS      = pcs;
        RegW     = regw;
        MemW     = memw;
        NoWrite  = nw;
        if (!rst_val) model_flags = RST_FLAGS;
        if (mid_rst) begin
            #1;
            reset = 1'b0;
            model_flags = RST_FLAGS;
        end
        p          = ref_pass(c, model_flags);
        e.tag      = tag;
        e.condex   = p;
        e.pcsrc    = pcs && p;
        e.memwrite = memw && p;
        e.regwrite = regw && p && !nw;
        e.flags    = model_flags;
        sb_q.push_back(e);
        if (reset && p) begin
            if (fw[1]) model_flags[3:2] = alu[3:2];
            if (fw[0]) model_flags[1:0] = alu[1:0];
        end
    endtask

    initial begin
        reset = 1'b0; Cond = '0; ALUFlags = '0; FlagW = '0;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
        model_flags = RST_FLAGS;

        // Reset state: gating stays combinational, EQ fails on zero flags
        step("rst_gate", 1'b0, 1'b0, 4'b0000, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
        step("rst_hold", 1'b0, 1'b0, 4'b1110, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);

        // Basic write with AL, then EQ sees Z
        step("al_write", 1'b1, 1'b0, 4'b1110, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
        step("eq_after", 1'b1, 1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        // Failed condition blocks flag write
        step("ne_block", 1'b1, 1'b0, 4'b0001, 2'b11, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b0);
        step("ne_held",  1'b1, 1'b0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        // Independent NZ / CV updates
        step("clr",      1'b1, 1'b0, 4'b1110, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step("nz_only",  1'b1, 1'b0, 4'b1110, 2'b10, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        step("cv_only",  1'b1, 1'b0, 4'b1110, 2'b01, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        step("both_set", 1'b1, 1'b0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        // NoWrite suppresses only the register write
        step("nowrite",  1'b1, 1'b0, 4'b1110, 2'b11, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b1);
        // Mid-cycle reset with flags 1010 and a write pending
        step("pre_rst",  1'b1, 1'b1, 4'b1110, 2'b11, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        step("in_rst",   1'b0, 1'b0, 4'b1110, 2'b11, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        step("release",  1'b1, 1'b0, 4'b1110, 2'b11, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        step("post_rst", 1'b1, 1'b0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full sweep: load each flag value, then test one condition
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                step("sweep_ld", 1'b1, 1'b0, 4'b1110, 2'b11, 4'(f), 1'b0, 1'b0, 1'b0, 1'b0);
                step("sweep",    1'b1, 1'b0, 4'(c),   2'b00, 4'(~f), 1'b1, 1'b1, 1'b1, 1'b0);
            end
        end

        // Random back-to-back traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'b1, 1'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 SHALL have parameter RESET_FLAGS, default 4'b0000, value loaded into the flag register {N,Z,C,V} on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Cond  input  4  instruction condition field, bits [31:28].
REQ-005 SHALL have port ALUFlags  input  4  ALU flags this cycle, bit order {N[3], Z[2], C[1], V[0]}.
REQ-006 SHALL have port FlagW  input  2  flag write request; [1] updates N,Z; [0] updates C,V.
REQ-007 SHALL have port PCS  input  1  decoder request to write PC.
REQ-008 SHALL have port RegW  input  1  decoder request to write the register file.
REQ-009 SHALL have port MemW  input  1  decoder request to write data memory.
REQ-010 SHALL have port NoWrite  input  1  suppresses the register write (CMP/CMN/TST/TEQ); flags still update.
REQ-011 SHALL have port PCSrc  output  1  gated PC write.
REQ-012 SHALL have port RegWrite  output  1  gated register-file write.
REQ-013 SHALL have port MemWrite  output  1  gated memory write.
REQ-014 SHALL have port CondEx  output  1  condition passed this cycle.
REQ-015 SHALL have port Flags  output  4  current stored flags {N,Z,C,V}.

Function
REQ-016 SHALL hold two state registers: NZ[1:0]={N,Z} and CV[1:0]={C,V}; Flags={NZ,CV}.
REQ-017 SHALL evaluate CondEx combinationally from Cond and the stored flags only, never from ALUFlags of the same cycle.
REQ-018 SHALL decode Cond: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
REQ-019 SHALL decode Cond: 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 1 (unconditional).
REQ-020 SHALL load NZ <= ALUFlags[3:2] on a rising clk edge iff FlagW[1] & CondEx.
REQ-021 SHALL load CV <= ALUFlags[1:0] on a rising clk edge iff FlagW[0] & CondEx.
REQ-022 SHALL allow NZ and CV to update independently or together in the same cycle.
REQ-023 SHALL make updated flags visible on Flags and CondEx one cycle after the write cycle (latency 1).
REQ-024 SHALL drive PCSrc = PCS & CondEx; MemWrite = MemW & CondEx; RegWrite = RegW & CondEx & ~NoWrite.
REQ-025 SHALL hold both flag registers unchanged when CondEx=0, regardless of FlagW.
REQ-026 SHALL treat back-to-back flag-setting instructions in consecutive cycles as sequential: the second evaluates against the first's written flags.
REQ-027 SHALL not gate any output with clk; outputs are glitch-tolerant combinational functions of inputs and state.

Reset
REQ-028 SHALL set {NZ,CV} to RESET_FLAGS immediately on reset falling, independent of clk.
REQ-029 SHALL hold flags at RESET_FLAGS while reset=0; flag writes requested during reset are ignored.
REQ-030 SHALL resume normal updates on the first rising clk edge after reset returns high.
REQ-031 SHALL keep output gating combinational during reset: with RESET_FLAGS=0000, Cond=0000 yields CondEx=0, all write enables 0.

Verification
REQ-032 Reset, then Cond=1110, FlagW=11, ALUFlags=0100, RegW=1 -> RegWrite=1 same cycle; next cycle Flags=0100, Cond=0000 gives CondEx=1.
REQ-033 Flags=0100, Cond=0001, FlagW=11, ALUFlags=1000 -> CondEx=0, no write; next cycle Flags still 0100.
REQ-034 Flags=0000, Cond=1110, FlagW=10, ALUFlags=1111 -> next cycle Flags=1100 (CV untouched); then FlagW=01, ALUFlags=0011 -> Flags=1111.
REQ-035 Sweep all 16 Cond values against all 16 stored flag values -> CondEx matches REQ-018/019 table in all 256 cases.
REQ-036 Cond=1110, RegW=1, NoWrite=1, MemW=1, PCS=1, FlagW=11 -> RegWrite=0, MemWrite=1, PCSrc=1, flags update next edge.
REQ-037 Assert reset mid-cycle with Flags=1010 and FlagW=11 pending -> Flags=RESET_FLAGS before next edge and after it; first post-reset edge accepts writes.
